// File: rtl/bp_be_pkg.sv
// Backend definitions shared by the dcache block-op issuer and its bench.
// Contents: block command encodings, the dcache opcode subset used by block
// ops, issuer FSM states, the cmd->opcode mapping and the dcache packet macros.

`ifndef BP_BE_PKG_MACROS_SV
`define BP_BE_PKG_MACROS_SV

// Packet layout, MSB first: opcode | vaddr | rd_addr
`define BP_BE_DECLARE_DCACHE_PKT_S(vaddr_width_mp) \
  typedef struct packed { \
    bp_be_dcache_fu_op_e                 opcode; \
    logic [vaddr_width_mp-1:0]           vaddr; \
    logic [reg_addr_width_gp-1:0]        rd_addr; \
  } bp_be_dcache_pkt_s

`define BP_BE_DCACHE_PKT_WIDTH(vaddr_width_mp) \
  (dcache_opcode_width_gp + (vaddr_width_mp) + reg_addr_width_gp)

`endif

package bp_be_pkg;

  localparam int reg_addr_width_gp      = 5;
  localparam int dcache_opcode_width_gp = 5;

  typedef enum logic [2:0] {
    e_block_bzero  = 3'd0,
    e_block_bload  = 3'd1,
    e_block_binval = 3'd2,
    e_block_bclean = 3'd3,
    e_block_bflush = 3'd4
  } bp_be_block_cmd_e;

  typedef enum logic [dcache_opcode_width_gp-1:0] {
    e_dcache_op_ld     = 5'd0,
    e_dcache_op_sd     = 5'd1,
    e_dcache_op_bzero  = 5'd20,
    e_dcache_op_bload  = 5'd21,
    e_dcache_op_binval = 5'd22,
    e_dcache_op_bclean = 5'd23,
    e_dcache_op_bflush = 5'd24
  } bp_be_dcache_fu_op_e;

  typedef enum logic [1:0] {
    e_issuer_idle  = 2'd0,
    e_issuer_issue = 2'd1,
    e_issuer_done  = 2'd2
  } bp_be_block_issuer_state_e;

  // Encodings 5..7 have no dcache counterpart and must issue nothing.
  function automatic logic block_cmd_is_mapped(input logic [2:0] cmd);
    return (cmd <= 3'd4);
  endfunction

  function automatic bp_be_dcache_fu_op_e block_cmd_to_dcache_op(input bp_be_block_cmd_e cmd);
    bp_be_dcache_fu_op_e op;
    case (cmd)
      e_block_bzero : op = e_dcache_op_bzero;
      e_block_bload : op = e_dcache_op_bload;
      e_block_binval: op = e_dcache_op_binval;
      e_block_bclean: op = e_dcache_op_bclean;
      e_block_bflush: op = e_dcache_op_bflush;
      default       : op = e_dcache_op_bzero;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/bp_be_dcache_block_op_issuer.sv
// Expands one block-range maintenance command into one dcache packet per
// cache block on a valid/ready-and stream, then pulses done with the count.
// Ports: cmd_* (command in), abort_i, pkt_* (packet stream out), busy_o,
// done_v_o/done_count_o (completion). Sync active-low reset_n_i on clk_i.

module bp_be_dcache_block_op_issuer
  import bp_be_pkg::*;
  #(parameter int vaddr_width_p        = 39
  , parameter int dcache_block_width_p = 512
  , parameter int max_blocks_p         = 64
  , localparam int count_width_lp      = $clog2(max_blocks_p+1)
  , localparam int block_bytes_lp      = dcache_block_width_p/8
  , localparam int dcache_pkt_width_lp = `BP_BE_DCACHE_PKT_WIDTH(vaddr_width_p)
  )
  (input  logic                           clk_i
  , input  logic                          reset_n_i

  , input  logic                          cmd_v_i
  , output logic                          cmd_ready_and_o
  , input  logic [2:0]                    cmd_op_i
  , input  logic [vaddr_width_p-1:0]      cmd_vaddr_i
  , input  logic [count_width_lp-1:0]     cmd_count_i

  , input  logic                          abort_i

  , output logic                          pkt_v_o
  , output logic [dcache_pkt_width_lp-1:0] pkt_o
  , input  logic                          pkt_ready_and_i

  , output logic                          busy_o
  , output logic                          done_v_o
  , output logic [count_width_lp-1:0]     done_count_o
  );

  `BP_BE_DECLARE_DCACHE_PKT_S(vaddr_width_p);

  localparam logic [vaddr_width_p-1:0] block_stride_lp = vaddr_width_p'(block_bytes_lp);
  localparam logic [vaddr_width_p-1:0] offset_mask_lp  = vaddr_width_p'(block_bytes_lp-1);

  bp_be_block_issuer_state_e state_q, state_n;
  bp_be_dcache_fu_op_e       op_q;
  logic [vaddr_width_p-1:0]  addr_q;
  logic [count_width_lp-1:0] remaining_q, issued_q;

  logic cmd_ready, accept, pkt_hs, cmd_mapped;
  logic [vaddr_width_p-1:0] vaddr_aligned;
  bp_be_dcache_pkt_s pkt;

  assign cmd_mapped    = block_cmd_is_mapped(cmd_op_i);
  assign vaddr_aligned = cmd_vaddr_i & ~offset_mask_lp;
  assign accept        = cmd_v_i & cmd_ready;
  assign pkt_hs        = pkt_v_o & pkt_ready_and_i;

  // Next state and all handshake outputs come from state only.
  always_comb begin
    state_n   = state_q;
    cmd_ready = 1'b0;
    pkt_v_o   = 1'b0;
    done_v_o  = 1'b0;
    unique case (state_q)
      e_issuer_idle: begin
        cmd_ready = 1'b1;
        if (cmd_v_i)
          state_n = (cmd_mapped && (cmd_count_i != '0)) ? e_issuer_issue : e_issuer_done;
      end
      e_issuer_issue: begin
        pkt_v_o = 1'b1;
        // A handshake coinciding with abort still lands in issued_q below.
        if (abort_i || (pkt_ready_and_i && (remaining_q == count_width_lp'(1))))
          state_n = e_issuer_done;
      end
      e_issuer_done: begin
        done_v_o = 1'b1;
        state_n  = e_issuer_idle;
      end
      default: state_n = e_issuer_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= e_issuer_idle;
      op_q        <= e_dcache_op_bzero;
      addr_q      <= '0;
      remaining_q <= '0;
      issued_q    <= '0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        op_q        <= block_cmd_to_dcache_op(bp_be_block_cmd_e'(cmd_op_i));
        addr_q      <= vaddr_aligned;
        remaining_q <= cmd_mapped ? cmd_count_i : '0;
        issued_q    <= '0;
      end else if (pkt_hs) begin
        // Address wraps silently at the top of the vaddr space.
        addr_q      <= addr_q + block_stride_lp;
        remaining_q <= remaining_q - count_width_lp'(1);
        issued_q    <= issued_q + count_width_lp'(1);
      end
    end
  end

  // Packet fields only move on a handshake, so they hold steady under stall.
  always_comb begin
    pkt         = '0;
    pkt.opcode  = op_q;
    pkt.vaddr   = addr_q;
    pkt.rd_addr = '0;
  end

  assign pkt_o           = pkt;
  assign cmd_ready_and_o = cmd_ready & reset_n_i;
  assign busy_o          = (state_q != e_issuer_idle);
  assign done_count_o    = issued_q;

endmodule
